// File: rtl/ram_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ram_arb_pkg
//   Shared encodings for the fetch/data RAM arbiter.
//   - state_t : arbiter FSM states (S_IDLE, S_ACCESS, S_RESP)
//   - owner_t : which requester owns the in-flight access (OWN_IF, OWN_D)
//   - AW_DEF / DW_DEF : default address and data widths
// ----------------------------------------------------------------------------
package ram_arb_pkg;

   localparam int AW_DEF = 64;
   localparam int DW_DEF = 64;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   // Encoding doubles as the bit index into the {d, if} grant vector.
   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// ----------------------------------------------------------------------------
// ram_arbiter_if
//   Bundles the fetch port, the data (load/store) port and the RAM pins.
//   modport slave  : the arbiter view (takes requests, drives grants,
//                    responses and the RAM address/write pins)
//   modport master : the environment view (requesters plus RAM instance)
//   Fetch : if_req, if_addr -> if_gnt, if_rvalid, if_rdata, if_err
//   Data  : d_req, d_we, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata, d_err
//   RAM   : ram_rw, ram_addr, ram_write -> ram_read, ram_exception
// ----------------------------------------------------------------------------
interface ram_arbiter_if
   import ram_arb_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
);

   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          if_err;

   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_gnt;
   logic          d_rvalid;
   logic [DW-1:0] d_rdata;
   logic          d_err;

   logic          ram_rw;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_write;
   logic [DW-1:0] ram_read;
   logic          ram_exception;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata, if_err,
      input  d_req, d_we, d_addr, d_wdata,
      output d_gnt, d_rvalid, d_rdata, d_err,
      output ram_rw, ram_addr, ram_write,
      input  ram_read, ram_exception
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata, if_err,
      output d_req, d_we, d_addr, d_wdata,
      input  d_gnt, d_rvalid, d_rdata, d_err,
      input  ram_rw, ram_addr, ram_write,
      output ram_read, ram_exception
   );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
//   Two-input arbiter for the RAM arbiter. Combinational grant.
//   Build option RAM_ARB_RR_EN:
//     defined   : round-robin; on a tie the port that did not win last gets
//                 the grant. last owner resets to OWN_D so fetch wins the
//                 first tie.
//     undefined : fixed priority, data (bit 1) over fetch (bit 0); no state.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     i_req[1:0] : requests, bit 0 = fetch, bit 1 = data
//     i_en       : grant slot open this cycle
//     o_gnt[1:0] : one-hot (or zero) grant
// ----------------------------------------------------------------------------
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_req,
   input  logic       i_en,
   output logic [1:0] o_gnt
);

   logic [1:0] w_gnt;

`ifdef RAM_ARB_RR_EN
   owner_t r_last;

   always_comb begin
      w_gnt = 2'b00;
      if (i_en) begin
         if (&i_req) w_gnt = (r_last == OWN_D) ? 2'b01 : 2'b10;
         else        w_gnt = i_req;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_last <= OWN_D;
      else if (|w_gnt) r_last <= w_gnt[1] ? OWN_D : OWN_IF;
   end
`else
   always_comb begin
      w_gnt = 2'b00;
      if (i_en) w_gnt = i_req[1] ? 2'b10 : {1'b0, i_req[0]};
   end

   // Fixed priority holds no state; clock and reset are intentionally idle.
   logic w_unused;
   assign w_unused = clk ^ rst_n;
`endif

   assign o_gnt = w_gnt;

endmodule

// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
//   Shares one single-port 64-bit RAM between the instruction-fetch port and
//   the data (load/store) port. One access every two cycles:
//     accept (IDLE/RESP) -> ACCESS (RAM pins driven) -> RESP (rvalid pulse)
//   Build option RAM_ARB_RR_EN selects round-robin tie breaking (see rr_arb2);
//   default is fixed data-over-fetch priority.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset, synchronous release
//     bus   : ram_arbiter_if.slave (fetch port, data port, RAM pins)
// ----------------------------------------------------------------------------
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
)(
   input  logic         clk,
   input  logic         rst_n,
   ram_arbiter_if.slave bus
);

   state_t        r_state;
   owner_t        r_own_p1;
   logic          r_we_p1;
   logic [AW-1:0] r_addr_p1;
   logic [DW-1:0] r_wdata_p1;
   logic [DW-1:0] r_rdata_p2;
   logic          r_err_p2;
   logic          r_if_vld_p2;
   logic          r_d_vld_p2;

   logic          w_slot_open;
   logic [1:0]    w_gnt;

   // Grants are only possible when the RAM is not being accessed.
   assign w_slot_open = (r_state == S_IDLE) || (r_state == S_RESP);

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_req ({bus.d_req, bus.if_req}),
      .i_en  (w_slot_open),
      .o_gnt (w_gnt)
   );

   assign bus.if_gnt = w_gnt[0];
   assign bus.d_gnt  = w_gnt[1];

   // ram_rw depends on the RAM's combinational range check of ram_addr,
   // so an out-of-range store never reaches the array.
   assign bus.ram_rw    = (r_state == S_ACCESS) && r_we_p1 && !bus.ram_exception;
   assign bus.ram_addr  = r_addr_p1;
   assign bus.ram_write = r_wdata_p1;

   assign bus.if_rvalid = r_if_vld_p2;
   assign bus.if_rdata  = r_rdata_p2;
   assign bus.if_err    = r_err_p2;
   assign bus.d_rvalid  = r_d_vld_p2;
   assign bus.d_rdata   = r_rdata_p2;
   assign bus.d_err     = r_err_p2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_own_p1    <= OWN_IF;
         r_we_p1     <= 1'b0;
         r_addr_p1   <= '0;
         r_wdata_p1  <= '0;
         r_rdata_p2  <= '0;
         r_err_p2    <= 1'b0;
         r_if_vld_p2 <= 1'b0;
         r_d_vld_p2  <= 1'b0;
      end else begin
         r_if_vld_p2 <= 1'b0;
         r_d_vld_p2  <= 1'b0;
         case (r_state)
            // Accept stage: latch the winner into the request registers.
            S_IDLE, S_RESP: begin
               if (|w_gnt) begin
                  r_state <= S_ACCESS;
                  if (w_gnt[1]) begin
                     r_own_p1   <= OWN_D;
                     r_we_p1    <= bus.d_we;
                     r_addr_p1  <= bus.d_addr;
                     r_wdata_p1 <= bus.d_wdata;
                  end else begin
                     r_own_p1   <= OWN_IF;
                     r_we_p1    <= 1'b0;
                     r_addr_p1  <= bus.if_addr;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            // Access stage: sample RAM result for the response stage.
            S_ACCESS: begin
               r_state     <= S_RESP;
               r_rdata_p2  <= (r_we_p1 || bus.ram_exception) ? '0 : bus.ram_read;
               r_err_p2    <= bus.ram_exception;
               r_if_vld_p2 <= (r_own_p1 == OWN_IF);
               r_d_vld_p2  <= (r_own_p1 == OWN_D);
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_arbiter
//   Directed bench for ram_arbiter with a behavioural 1024 x 64-bit RAM
//   (addresses >= 0x2000 flag ram_exception). Honours RAM_ARB_RR_EN.
// ----------------------------------------------------------------------------
module tb_ram_arbiter;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   logic [63:0] mem [0:1023];

   ram_arbiter_if #(.AW(64), .DW(64)) bus ();

   ram_arbiter #(.AW(64), .DW(64)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: combinational read/range check, synchronous write.
   // Index uses addr[12:3] only, so a write leaking through at an
   // out-of-range address would alias onto a low cell.
   assign bus.ram_exception = (bus.ram_addr >= 64'h2000);
   assign bus.ram_read      = bus.ram_exception ? 64'h0 : mem[bus.ram_addr[12:3]];
   always @(posedge clk) if (bus.ram_rw) mem[bus.ram_addr[12:3]] <= bus.ram_write;

   task automatic idle_inputs();
      bus.if_req  = 1'b0;
      bus.if_addr = '0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err, bus.ram_rw} !== 7'b0) begin
         n_bad++; $display("FAIL reset_ctrl: got %b expected 0000000",
            {bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err, bus.ram_rw});
      end
      n_cmp++;
      if ((bus.ram_addr | bus.ram_write | bus.if_rdata | bus.d_rdata) !== 64'h0) begin
         n_bad++; $display("FAIL reset_data: got %h expected 0",
            bus.ram_addr | bus.ram_write | bus.if_rdata | bus.d_rdata);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_load();
      mem[2] = 64'hDEAD_BEEF;
      @(posedge clk); #1;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h10;
      @(negedge clk);
      n_cmp++;
      if ({bus.d_gnt, bus.if_gnt} !== 2'b10) begin
         n_bad++; $display("FAIL load_gnt: got %b expected 10", {bus.d_gnt, bus.if_gnt});
      end
      @(posedge clk); #1 bus.d_req = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({bus.ram_rw, bus.d_rvalid} !== 2'b00 || bus.ram_addr !== 64'h10) begin
         n_bad++; $display("FAIL load_access: got rw/rvalid %b addr %h expected 00 / 10",
            {bus.ram_rw, bus.d_rvalid}, bus.ram_addr);
      end
      @(negedge clk);
      n_cmp++;
      if ({bus.d_rvalid, bus.d_err, bus.if_rvalid} !== 3'b100 || bus.d_rdata !== 64'hDEAD_BEEF) begin
         n_bad++; $display("FAIL load_resp: got v/e/ifv %b data %h expected 100 / deadbeef",
            {bus.d_rvalid, bus.d_err, bus.if_rvalid}, bus.d_rdata);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.d_rvalid !== 1'b0) begin
         n_bad++; $display("FAIL load_pulse: got %b expected 0", bus.d_rvalid);
      end
   endtask

   task automatic test_store();
      @(posedge clk); #1;
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 64'h3; bus.d_wdata = 64'h1234;
      @(negedge clk);
      n_cmp++;
      if (bus.d_gnt !== 1'b1) begin
         n_bad++; $display("FAIL store_gnt: got %b expected 1", bus.d_gnt);
      end
      @(posedge clk); #1 begin bus.d_req = 1'b0; bus.d_we = 1'b0; end
      @(negedge clk);
      n_cmp++;
      if (bus.ram_rw !== 1'b1 || bus.ram_addr !== 64'h3 || bus.ram_write !== 64'h1234) begin
         n_bad++; $display("FAIL store_access: got rw %b addr %h wdata %h expected 1 / 3 / 1234",
            bus.ram_rw, bus.ram_addr, bus.ram_write);
      end
      @(negedge clk);
      n_cmp++;
      if ({bus.ram_rw, bus.d_rvalid, bus.d_err} !== 3'b010 || bus.d_rdata !== 64'h0) begin
         n_bad++; $display("FAIL store_resp: got rw/v/e %b data %h expected 010 / 0",
            {bus.ram_rw, bus.d_rvalid, bus.d_err}, bus.d_rdata);
      end
      n_cmp++;
      if (mem[0] !== 64'h1234) begin
         n_bad++; $display("FAIL store_mem: got %h expected 1234", mem[0]);
      end
   endtask

   task automatic test_tie();
      logic exp_if, exp_d;
      @(posedge clk); #1;
      bus.if_req = 1'b1; bus.if_addr = 64'h0;
      bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
`ifdef RAM_ARB_RR_EN
         exp_if = (k % 4 == 0);
         exp_d  = (k % 4 == 2);
`else
         exp_if = 1'b0;
         exp_d  = (k % 2 == 0);
`endif
         n_cmp++;
         if ({bus.if_gnt, bus.d_gnt} !== {exp_if, exp_d}) begin
            n_bad++; $display("FAIL tie_gnt[%0d]: got if/d %b expected %b", k,
               {bus.if_gnt, bus.d_gnt}, {exp_if, exp_d});
         end
         if (k == 2) begin
            n_cmp++;
`ifdef RAM_ARB_RR_EN
            if ({bus.if_rvalid, bus.d_rvalid} !== 2'b10) begin
               n_bad++; $display("FAIL tie_owner: got if/d rvalid %b expected 10", {bus.if_rvalid, bus.d_rvalid});
            end
`else
            if ({bus.if_rvalid, bus.d_rvalid} !== 2'b01) begin
               n_bad++; $display("FAIL tie_owner: got if/d rvalid %b expected 01", {bus.if_rvalid, bus.d_rvalid});
            end
`endif
         end
         @(posedge clk); #1;
      end
      idle_inputs();
      repeat (3) @(posedge clk);
   endtask

   task automatic test_out_of_range();
      @(posedge clk); #1;
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 64'h1_0000; bus.d_wdata = 64'hBAD0_BAD0;
      @(posedge clk); #1 begin bus.d_req = 1'b0; bus.d_we = 1'b0; end
      @(negedge clk);
      n_cmp++;
      if (bus.ram_rw !== 1'b0 || bus.ram_addr !== 64'h1_0000) begin
         n_bad++; $display("FAIL oob_access: got rw %b addr %h expected 0 / 10000", bus.ram_rw, bus.ram_addr);
      end
      @(negedge clk);
      n_cmp++;
      if ({bus.d_rvalid, bus.d_err} !== 2'b11 || bus.d_rdata !== 64'h0) begin
         n_bad++; $display("FAIL oob_resp: got v/e %b data %h expected 11 / 0", {bus.d_rvalid, bus.d_err}, bus.d_rdata);
      end
      n_cmp++;
      if (mem[0] !== 64'h1234) begin
         n_bad++; $display("FAIL oob_mem: got %h expected 1234", mem[0]);
      end
      @(posedge clk);
   endtask

   task automatic test_reset_mid();
      mem[1] = 64'h0;
      @(posedge clk); #1;
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 64'h8; bus.d_wdata = 64'h55;
      @(posedge clk); #1 begin bus.d_req = 1'b0; bus.d_we = 1'b0; end
      n_cmp++;
      if (bus.ram_rw !== 1'b1) begin
         n_bad++; $display("FAIL mid_pre: got rw %b expected 1", bus.ram_rw);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.ram_rw !== 1'b0) begin
         n_bad++; $display("FAIL mid_rw: got %b expected 0", bus.ram_rw);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({bus.if_rvalid, bus.d_rvalid} !== 2'b00) begin
            n_bad++; $display("FAIL mid_norsp[%0d]: got %b expected 00", k, {bus.if_rvalid, bus.d_rvalid});
         end
      end
      n_cmp++;
      if (mem[1] !== 64'h0) begin
         n_bad++; $display("FAIL mid_mem: got %h expected 0", mem[1]);
      end
      @(posedge clk); #1;
      bus.d_req = 1'b1; bus.d_addr = 64'h10;
      @(posedge clk); #1 bus.d_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 64'hDEAD_BEEF) begin
         n_bad++; $display("FAIL mid_after: got v %b data %h expected 1 / deadbeef", bus.d_rvalid, bus.d_rdata);
      end
      @(posedge clk);
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp_data [3];
      logic [63:0] addrs [3];
      exp_data[0] = 64'h1111_0000; exp_data[1] = 64'h2222_0000; exp_data[2] = 64'h3333_0000;
      addrs[0] = 64'h0; addrs[1] = 64'h8; addrs[2] = 64'h10;
      mem[0] = exp_data[0]; mem[1] = exp_data[1]; mem[2] = exp_data[2];
      for (int c = 0; c < 7; c++) begin
         @(posedge clk); #1;
         bus.if_req  = (c <= 4);
         bus.if_addr = addrs[(c <= 4) ? c / 2 : 2];
         @(negedge clk);
         n_cmp++;
         if (bus.if_gnt !== ((c % 2 == 0) && (c <= 4))) begin
            n_bad++; $display("FAIL b2b_gnt[%0d]: got %b expected %b", c, bus.if_gnt, (c % 2 == 0) && (c <= 4));
         end
         if (c == 2 || c == 4 || c == 6) begin
            n_cmp++;
            if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== exp_data[c / 2 - 1]) begin
               n_bad++; $display("FAIL b2b_resp[%0d]: got v %b data %h expected 1 / %h", c,
                  bus.if_rvalid, bus.if_rdata, exp_data[c / 2 - 1]);
            end
         end else if (c != 0) begin
            n_cmp++;
            if (bus.if_rvalid !== 1'b0) begin
               n_bad++; $display("FAIL b2b_gap[%0d]: got %b expected 0", c, bus.if_rvalid);
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 64'h0;
      test_reset();
      test_load();
      test_store();
      test_tie();
      test_out_of_range();
      test_reset_mid();
      test_back_to_back();
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
